// File: rtl/vacc_pkg.sv
// Shared width helpers for the ping-pong vector accumulator.
// Every width in the block is derived from the three top-level parameters here.
package vacc_pkg;

  // Ceiling log2 as a constant function; $clog2(n) returns the same value.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int input_width, input int acc_len_bits);
    return input_width + acc_len_bits;
  endfunction

  // One extra MSB selects the ping or pong half of the result RAM.
  function automatic int addr_width(input int vector_length);
    return log2(vector_length) + 1;
  endfunction

  function automatic int ctr_width(input int acc_len_bits, input int vector_length);
    return acc_len_bits + log2(vector_length);
  endfunction

endpackage

// File: rtl/vector_acc_pingpong_if.sv
// Sample stream, read-port and debug bundle of the ping-pong accumulator.
interface vector_acc_pingpong_if
  import vacc_pkg::*;
#(
  parameter int INPUT_WIDTH   = 4,
  parameter int ACC_LEN_BITS  = 8,
  parameter int VECTOR_LENGTH = 32
);
  localparam int VEC_BITS  = log2(VECTOR_LENGTH);
  localparam int ACC_WIDTH = acc_width(INPUT_WIDTH, ACC_LEN_BITS);
  localparam int CTR_BITS  = ctr_width(ACC_LEN_BITS, VECTOR_LENGTH);

  // There is no valid/ready pair: one din sample is consumed on every rising
  // clock edge with no backpressure, sync restarts the framing on the next
  // sample, and dout_* follow their read addresses two cycles later.
  logic                          sync;
  logic signed [INPUT_WIDTH-1:0] din;
  logic                          buf_sel;
  logic [VEC_BITS-1:0]           ant_sel_a;
  logic [VEC_BITS-1:0]           ant_sel_b;
  logic signed [ACC_WIDTH-1:0]   dout_a;
  logic signed [ACC_WIDTH-1:0]   dout_b;
  logic [CTR_BITS-1:0]           dbg_ctr;
  logic                          dbg_active_ram;

  modport master (
    output sync, din, buf_sel, ant_sel_a, ant_sel_b,
    input  dout_a, dout_b, dbg_ctr, dbg_active_ram
  );

  modport slave (
    input  sync, din, buf_sel, ant_sel_a, ant_sel_b,
    output dout_a, dout_b, dbg_ctr, dbg_active_ram
  );

endinterface

// File: rtl/vacc_dpram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module vacc_dpram #(
  parameter int DATA = 8,
  parameter int ADDR = 6
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR-1:0] waddr,
  input  logic [DATA-1:0] wdata,
  input  logic [ADDR-1:0] raddr,
  output logic [DATA-1:0] rdata
);

  logic [DATA-1:0] mem [0:(1<<ADDR)-1];

  // Contents are never reset; a same-address read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vector_acc_pingpong.sv
// Integrates ACC_LEN samples per vector element and stores each sum into the
// active half of a duplicated result RAM that flips every full vector round.
module vector_acc_pingpong
  import vacc_pkg::*;
#(
  parameter int INPUT_WIDTH   = 4,
  parameter int ACC_LEN_BITS  = 8,
  parameter int VECTOR_LENGTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  vector_acc_pingpong_if.slave bus
);

  localparam int VEC_BITS   = log2(VECTOR_LENGTH);
  localparam int ACC_WIDTH  = acc_width(INPUT_WIDTH, ACC_LEN_BITS);
  localparam int ADDR_WIDTH = addr_width(VECTOR_LENGTH);
  localparam int CTR_BITS   = ctr_width(ACC_LEN_BITS, VECTOR_LENGTH);
  localparam logic [ACC_LEN_BITS-1:0] LAST_SAMPLE = '1;

  logic [CTR_BITS-1:0]     ctr;
  logic                    active_ram;
  logic [ACC_LEN_BITS-1:0] sample_index;
  logic [VEC_BITS-1:0]     vec_index;

  assign sample_index = ctr[ACC_LEN_BITS-1:0];
  assign vec_index    = ctr[CTR_BITS-1:ACC_LEN_BITS];

  // Counter wraps naturally at ACC_LEN*VECTOR_LENGTH-1; sync beats the toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr        <= '0;
      active_ram <= 1'b0;
    end else if (bus.sync) begin
      ctr        <= '0;
      active_ram <= 1'b0;
    end else begin
      ctr <= ctr + CTR_BITS'(1);
      if (ctr == '1) active_ram <= ~active_ram;
    end
  end

  // Stage 1: register the sign-extended sample with its framing.
  logic signed [ACC_WIDTH-1:0] s1_data;
  logic                        s1_valid;
  logic                        s1_first;
  logic                        s1_last;
  logic [VEC_BITS-1:0]         s1_vec;
  logic                        s1_ram;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_vec   <= '0;
      s1_ram   <= 1'b0;
    end else begin
      s1_data  <= {{ACC_LEN_BITS{bus.din[INPUT_WIDTH-1]}}, bus.din};
      s1_valid <= ~bus.sync;
      s1_first <= (sample_index == '0);
      s1_last  <= (sample_index == LAST_SAMPLE);
      s1_vec   <= vec_index;
      s1_ram   <= active_ram;
    end
  end

  // Stage 2: the first sample of an element reloads the sum, which also
  // throws away whatever partial sum a sync interrupted.
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        s2_wr;
  logic [VEC_BITS-1:0]         s2_vec;
  logic                        s2_ram;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      s2_wr  <= 1'b0;
      s2_vec <= '0;
      s2_ram <= 1'b0;
    end else begin
      if (s1_valid) acc <= s1_first ? s1_data : acc + s1_data;
      s2_wr  <= s1_valid & s1_last;
      s2_vec <= s1_vec;
      s2_ram <= s1_ram;
    end
  end

  // Stage 3: write register; the RAM commits on the following edge.
  logic                        wr_en;
  logic signed [ACC_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0]       wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
    end else begin
      wr_en   <= s2_wr;
      wr_data <= acc;
      wr_addr <= {s2_ram, s2_vec};
    end
  end

  // Two identical copies give two independent read ports.
  logic [ACC_WIDTH-1:0] rd_a;
  logic [ACC_WIDTH-1:0] rd_b;

  vacc_dpram #(.DATA(ACC_WIDTH), .ADDR(ADDR_WIDTH)) u_ram_a (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr ({bus.buf_sel, bus.ant_sel_a}),
    .rdata (rd_a)
  );

  vacc_dpram #(.DATA(ACC_WIDTH), .ADDR(ADDR_WIDTH)) u_ram_b (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr ({bus.buf_sel, bus.ant_sel_b}),
    .rdata (rd_b)
  );

  logic signed [ACC_WIDTH-1:0] dout_a_q;
  logic signed [ACC_WIDTH-1:0] dout_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= rd_a;
      dout_b_q <= rd_b;
    end
  end

  assign bus.dout_a         = dout_a_q;
  assign bus.dout_b         = dout_b_q;
  assign bus.dbg_ctr        = ctr;
  assign bus.dbg_active_ram = active_ram;

endmodule

// File: tb/tb_vector_acc_pingpong.sv
// Directed bench for vector_acc_pingpong with INPUT_WIDTH=4, ACC_LEN=4, 4 elements.
module tb_vector_acc_pingpong;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;
  logic signed [31:0] exp_q[$];

  vector_acc_pingpong_if #(.INPUT_WIDTH(4), .ACC_LEN_BITS(2), .VECTOR_LENGTH(4)) bus ();

  vector_acc_pingpong #(.INPUT_WIDTH(4), .ACC_LEN_BITS(2), .VECTOR_LENGTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change only at the falling edge; each call ends on a falling edge.
  task automatic feed(input logic signed [3:0] v, input int n);
    bus.din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_sync();
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic bs, input int a, input int b,
                            input int ea, input int eb);
    bus.buf_sel   = bs;
    bus.ant_sel_a = 2'(a);
    bus.ant_sel_b = 2'(b);
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    repeat (2) @(negedge clk);
    check({tag, "_a"}, int'(bus.dout_a), exp_q.pop_front());
    check({tag, "_b"}, int'(bus.dout_b), exp_q.pop_front());
  endtask

  initial begin
    bus.sync = 1'b0;
    bus.din = '0;
    bus.buf_sel = 1'b0;
    bus.ant_sel_a = '0;
    bus.ant_sel_b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout_a", int'(bus.dout_a), 0);
    check("rst_dout_b", int'(bus.dout_b), 0);
    check("rst_ctr", int'(bus.dbg_ctr), 0);
    check("rst_active", int'(bus.dbg_active_ram), 0);

    // 1: all ones for one round after reset release
    rst_n = 1'b1;
    feed(4'sd1, 16);
    read_check("t1_ones", 1'b0, 2, 0, 4, 4);

    // 2: extreme inputs
    do_sync();
    feed(-4'sd8, 19);
    read_check("t2_min01", 1'b0, 0, 1, -32, -32);
    read_check("t2_min23", 1'b0, 2, 3, -32, -32);
    do_sync();
    feed(4'sd7, 19);
    read_check("t2_max03", 1'b0, 0, 3, 28, 28);
    read_check("t2_max12", 1'b0, 1, 2, 28, 28);

    // 3: ping-pong, plus the two-cycle read latency on a buffer switch
    do_sync();
    feed(4'sd1, 16);
    feed(4'sd3, 16);
    feed(4'sd1, 3);
    read_check("t3_b1_03", 1'b1, 0, 3, 12, 12);
    bus.buf_sel = 1'b0;
    @(negedge clk);
    check("t3_lat1_a", int'(bus.dout_a), 12);
    @(negedge clk);
    check("t3_lat2_a", int'(bus.dout_a), 4);
    check("t3_lat2_b", int'(bus.dout_b), 4);
    read_check("t3_b0_12", 1'b0, 1, 2, 4, 4);
    read_check("t3_b1_12", 1'b1, 1, 2, 12, 12);

    // 4: per-element pattern; element 3 read exactly on its write edge
    do_sync();
    feed(-4'sd2, 4);
    feed(-4'sd1, 4);
    feed(4'sd0, 4);
    feed(4'sd5, 4);
    feed(4'sd0, 2);
    bus.buf_sel = 1'b0;
    bus.ant_sel_a = 2'd3;
    bus.ant_sel_b = 2'd3;
    repeat (2) @(negedge clk);
    check("t4_rdw_old", int'(bus.dout_a), 4);
    @(negedge clk);
    check("t4_rdw_new", int'(bus.dout_b), 20);
    read_check("t4_e01", 1'b0, 0, 1, -8, -4);
    read_check("t4_e23", 1'b0, 2, 3, 0, 20);

    // 5: sync in the middle of element 2 of buffer 1
    do_sync();
    feed(4'sd3, 24);
    feed(4'sd1, 2);
    check("t5_active_pre", int'(bus.dbg_active_ram), 1);
    do_sync();
    check("t5_ctr_sync", int'(bus.dbg_ctr), 0);
    check("t5_active_sync", int'(bus.dbg_active_ram), 0);
    feed(4'sd2, 7);
    read_check("t5_b0", 1'b0, 0, 1, 8, 12);
    read_check("t5_b1", 1'b1, 2, 0, 12, 12);

    // sync coinciding with the round wrap keeps buffer 0
    do_sync();
    feed(4'sd2, 15);
    check("wrap_ctr_pre", int'(bus.dbg_ctr), 15);
    check("wrap_active_pre", int'(bus.dbg_active_ram), 0);
    do_sync();
    check("wrap_ctr", int'(bus.dbg_ctr), 0);
    check("wrap_active", int'(bus.dbg_active_ram), 0);

    // 6: asynchronous reset mid-accumulation, then restart
    bus.din = 4'sd3;
    read_check("t6_pre", 1'b1, 2, 3, 12, 12);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_a", int'(bus.dout_a), 0);
    check("t6_async_b", int'(bus.dout_b), 0);
    check("t6_async_ctr", int'(bus.dbg_ctr), 0);
    check("t6_async_active", int'(bus.dbg_active_ram), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    feed(4'sd1, 1);
    check("t6_ctr_restart", int'(bus.dbg_ctr), 1);
    check("t6_active_restart", int'(bus.dbg_active_ram), 0);
    feed(4'sd1, 6);
    read_check("t6_post", 1'b0, 0, 1, 4, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
